sram_bus_responder: RTL and testbench

Responder end of the backend's bus query channel. It accepts a single outstanding word request from the LSU side: a read, or a byte-enabled write. It executes the request as a multi-cycle, wait-stated access on an asynchronous external SRAM and returns a one-cycle response with read data or an error flag. It sits between the backend's bus request/response ports and the board SRAM pins.

---
 rtl/sram_bus_responder.sv | 213 +++++++++++++++++++++
 tb/tb_sram_bus_responder.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_bus_responder.sv
// sram_bus_responder
// Bus-side responder for an asynchronous external SRAM. Accepts one word
// request at a time (read or byte-enabled write), runs it as a wait-stated
// SRAM cycle and returns a single-cycle response pulse. Every output,
// including all SRAM pins, comes straight from a flop.

module sram_bus_responder #(
  parameter logic [31:0] ADDR_BASE      = 32'h8000_0000,
  parameter int          ADDR_SIZE_LOG2 = 22,
  parameter int          READ_WAIT      = 2,
  parameter int          WRITE_WAIT     = 2
) (
  input  logic                      clk,
  input  logic                      rst,

  // request / response channel
  input  logic                      req_valid,
  input  logic                      req_we,
  input  logic [31:0]               req_addr,
  input  logic [31:0]               req_wdata,
  input  logic [3:0]                req_be,
  output logic                      resp_valid,
  output logic [31:0]               resp_rdata,
  output logic                      resp_error,
  output logic                      busy,

  // SRAM pins
  output logic [ADDR_SIZE_LOG2-3:0] sram_addr,
  output logic [31:0]               sram_data_out,
  output logic                      sram_data_oe,
  input  logic [31:0]               sram_data_in,
  output logic                      sram_ce_n,
  output logic                      sram_oe_n,
  output logic                      sram_we_n,
  output logic [3:0]                sram_be_n
);

  localparam int AW       = ADDR_SIZE_LOG2 - 2;
  localparam int MAX_WAIT = (READ_WAIT > WRITE_WAIT) ? READ_WAIT : WRITE_WAIT;
  // The counter only ever holds values up to MAX_WAIT-1.
  localparam int CNT_W    = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO   = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] READ_LOAD  = CNT_W'(READ_WAIT - 1);
  localparam logic [CNT_W-1:0] WRITE_LOAD = CNT_W'(WRITE_WAIT - 1);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_HOLD  = 3'd4,
    ST_DONE     = 3'd5
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] wait_cnt_r;

  logic [31:0]      offset_s;
  logic             out_of_window_s;
  logic [AW-1:0]    word_addr_s;
  logic             write_nop_s;

  // Byte offset into the window; anything at or above 2^ADDR_SIZE_LOG2
  // (including addresses below the base, which wrap) is outside.
  function automatic logic outside_window(input logic [31:0] offset);
    outside_window = ((offset >> ADDR_SIZE_LOG2) != 32'h0000_0000);
  endfunction

  // Word index inside the window; the two byte-lane bits are dropped.
  function automatic logic [AW-1:0] word_index(input logic [31:0] offset);
    word_index = offset[ADDR_SIZE_LOG2-1:2];
  endfunction

  // Decode the incoming request address and classify the request.
  always_comb begin
    offset_s        = req_addr - ADDR_BASE;
    out_of_window_s = outside_window(offset_s);
    word_addr_s     = word_index(offset_s);
    if (req_we && (req_be == 4'b0000)) begin
      write_nop_s = 1'b1;
    end else begin
      write_nop_s = 1'b0;
    end
  end

  // Access sequencer: owns the FSM state, wait counter, SRAM pins and response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      wait_cnt_r    <= CNT_ZERO;
      resp_valid    <= 1'b0;
      resp_rdata    <= 32'h0000_0000;
      resp_error    <= 1'b0;
      busy          <= 1'b0;
      sram_addr     <= '0;
      sram_data_out <= 32'h0000_0000;
      sram_data_oe  <= 1'b0;
      sram_ce_n     <= 1'b1;
      sram_oe_n     <= 1'b1;
      sram_we_n     <= 1'b1;
      sram_be_n     <= 4'b1111;
    end else begin
      // The response pulse lasts one cycle unless a state below raises it.
      resp_valid <= 1'b0;

      case (state_r)
        ST_IDLE: begin
          if (req_valid) begin
            busy <= 1'b1;
            if (out_of_window_s) begin
              // Rejected without touching the SRAM.
              state_r    <= ST_DONE;
              resp_valid <= 1'b1;
              resp_error <= 1'b1;
              resp_rdata <= 32'h0000_0000;
            end else if (write_nop_s) begin
              // A write with no lanes enabled completes immediately.
              state_r    <= ST_DONE;
              resp_valid <= 1'b1;
              resp_error <= 1'b0;
              resp_rdata <= 32'h0000_0000;
            end else if (!req_we) begin
              state_r      <= ST_RD;
              wait_cnt_r   <= READ_LOAD;
              sram_addr    <= word_addr_s;
              sram_data_oe <= 1'b0;
              sram_ce_n    <= 1'b0;
              sram_oe_n    <= 1'b0;
              sram_we_n    <= 1'b1;
              sram_be_n    <= 4'b0000;
            end else begin
              // Address, data and lanes settle a full cycle before we_n falls.
              state_r       <= ST_WR_SETUP;
              sram_addr     <= word_addr_s;
              sram_data_out <= req_wdata;
              sram_data_oe  <= 1'b1;
              sram_ce_n     <= 1'b0;
              sram_oe_n     <= 1'b1;
              sram_we_n     <= 1'b1;
              sram_be_n     <= ~req_be;
            end
          end else begin
            busy <= 1'b0;
          end
        end

        ST_RD: begin
          if (wait_cnt_r == CNT_ZERO) begin
            // Last wait cycle: sample the pad and release the SRAM.
            state_r      <= ST_DONE;
            resp_valid   <= 1'b1;
            resp_rdata   <= sram_data_in;
            resp_error   <= 1'b0;
            sram_data_oe <= 1'b0;
            sram_ce_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
            sram_we_n    <= 1'b1;
            sram_be_n    <= 4'b1111;
          end else begin
            wait_cnt_r <= wait_cnt_r - CNT_ONE;
          end
        end

        ST_WR_SETUP: begin
          state_r    <= ST_WR_PULSE;
          wait_cnt_r <= WRITE_LOAD;
          sram_we_n  <= 1'b0;
        end

        ST_WR_PULSE: begin
          if (wait_cnt_r == CNT_ZERO) begin
            // Raise we_n but keep address, data and lanes for one more cycle.
            state_r   <= ST_WR_HOLD;
            sram_we_n <= 1'b1;
          end else begin
            wait_cnt_r <= wait_cnt_r - CNT_ONE;
          end
        end

        ST_WR_HOLD: begin
          state_r      <= ST_DONE;
          resp_valid   <= 1'b1;
          resp_rdata   <= 32'h0000_0000;
          resp_error   <= 1'b0;
          sram_data_oe <= 1'b0;
          sram_ce_n    <= 1'b1;
          sram_oe_n    <= 1'b1;
          sram_we_n    <= 1'b1;
          sram_be_n    <= 4'b1111;
        end

        ST_DONE: begin
          // req_valid is deliberately ignored here.
          state_r <= ST_IDLE;
          busy    <= 1'b0;
        end

        default: begin
          state_r      <= ST_IDLE;
          busy         <= 1'b0;
          sram_data_oe <= 1'b0;
          sram_ce_n    <= 1'b1;
          sram_oe_n    <= 1'b1;
          sram_we_n    <= 1'b1;
          sram_be_n    <= 4'b1111;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_bus_responder.sv
// tb_sram_bus_responder
// Randomised and directed requests against a word-level memory model;
// expected latency, strobe windows, data and error come from the bus rules.

module tb_sram_bus_responder;

  localparam logic [31:0] ADDR_BASE      = 32'h8000_0000;
  localparam int          ADDR_SIZE_LOG2 = 22;
  localparam int          READ_WAIT      = 2;
  localparam int          WRITE_WAIT     = 2;
  localparam logic [31:0] WIN_BYTES      = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        busy;
  logic [19:0] sram_addr;
  logic [31:0] sram_data_out;
  logic        sram_data_oe;
  logic [31:0] sram_data_in;
  logic        sram_ce_n;
  logic        sram_oe_n;
  logic        sram_we_n;
  logic [3:0]  sram_be_n;

  always #5 clk = ~clk;

  sram_bus_responder #(
    .ADDR_BASE      (ADDR_BASE),
    .ADDR_SIZE_LOG2 (ADDR_SIZE_LOG2),
    .READ_WAIT      (READ_WAIT),
    .WRITE_WAIT     (WRITE_WAIT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_we        (req_we),
    .req_addr      (req_addr),
    .req_wdata     (req_wdata),
    .req_be        (req_be),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_error    (resp_error),
    .busy          (busy),
    .sram_addr     (sram_addr),
    .sram_data_out (sram_data_out),
    .sram_data_oe  (sram_data_oe),
    .sram_data_in  (sram_data_in),
    .sram_ce_n     (sram_ce_n),
    .sram_oe_n     (sram_oe_n),
    .sram_we_n     (sram_we_n),
    .sram_be_n     (sram_be_n)
  );

  int n_vec  = 0;
  int n_miss = 0;

  logic [31:0] sram_mem [int unsigned];  // contents of the external chip
  logic [31:0] ref_mem  [int unsigned];  // what the bus should have stored

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_w, input logic [31:0] new_w,
                                              input logic [3:0] lanes);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) begin
      if (lanes[b]) r[8*b +: 8] = new_w[8*b +: 8];
    end
    return r;
  endfunction

  function automatic logic [31:0] sram_rd(input logic [19:0] a);
    return sram_mem.exists(32'(a)) ? sram_mem[32'(a)] : 32'h0;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [19:0] a);
    return ref_mem.exists(32'(a)) ? ref_mem[32'(a)] : 32'h0;
  endfunction

  // Advance one cycle and let the chip model react to the pins of the new cycle.
  task automatic tick();
    @(posedge clk);
    #1;
    if (!sram_ce_n && !sram_we_n)
      sram_mem[32'(sram_addr)] = merge_bytes(sram_rd(sram_addr), sram_data_out, ~sram_be_n);
    sram_data_in = (!sram_ce_n && !sram_oe_n) ? sram_rd(sram_addr) : 32'h0;
  endtask

  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be);
    logic [31:0] off;
    logic [19:0] waddr;
    logic        err, active, got;
    logic [31:0] exp_rdata, obs_rdata;
    logic        obs_err;
    int exp_lat, lat, oe_cnt, we_cnt, oe_first, we_first, ce_cnt, busy_cnt, bad;

    off       = addr - ADDR_BASE;
    err       = (off >= WIN_BYTES);
    waddr     = off[21:2];
    active    = !err && !(we && (be == 4'b0000));
    exp_lat   = !active ? 1 : (we ? WRITE_WAIT + 3 : READ_WAIT + 1);
    exp_rdata = err ? 32'h0 : ref_rd(waddr);

    tick();                                  // cycle 0
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    req_be    = be;

    got = 1'b0; lat = 0; oe_cnt = 0; we_cnt = 0; oe_first = -1; we_first = -1;
    ce_cnt = 0; busy_cnt = 0; bad = 0; obs_rdata = 32'h0; obs_err = 1'b0;
    for (int c = 1; c <= 40 && !got; c++) begin
      tick();
      if (busy) busy_cnt++;
      if (!sram_oe_n) begin oe_cnt++; if (oe_first < 0) oe_first = c; end
      if (!sram_we_n) begin we_cnt++; if (we_first < 0) we_first = c; end
      if (!sram_ce_n) begin
        ce_cnt++;
        if (sram_addr != waddr) bad++;
        if (we) begin
          if (!sram_data_oe || sram_data_out != wdata || sram_be_n != ~be || !sram_oe_n) bad++;
        end else begin
          if (sram_data_oe || sram_be_n != 4'b0000 || !sram_we_n) bad++;
        end
      end
      if (resp_valid) begin
        got       = 1'b1;
        lat       = c;
        obs_rdata = resp_rdata;
        obs_err   = resp_error;
        req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;

    check_eq("resp_seen", {31'h0, got}, 32'd1);
    if (got) begin
      check_eq("latency", 32'(lat), 32'(exp_lat));
      check_eq("error", {31'h0, obs_err}, {31'h0, err});
      if (!we || err) check_eq("rdata", obs_rdata, exp_rdata);
      check_eq("oe_low_cycles", 32'(oe_cnt), (active && !we) ? 32'(READ_WAIT) : 32'd0);
      check_eq("we_low_cycles", 32'(we_cnt), (active && we) ? 32'(WRITE_WAIT) : 32'd0);
      if (active && !we) check_eq("oe_first_cycle", 32'(oe_first), 32'd1);
      if (active && we)  check_eq("we_first_cycle", 32'(we_first), 32'd2);
      check_eq("ce_low_cycles", 32'(ce_cnt), active ? 32'(exp_lat - 1) : 32'd0);
      check_eq("busy_cycles", 32'(busy_cnt), 32'(exp_lat));
      check_eq("pin_stability", 32'(bad), 32'd0);
      tick();                                // DONE+1, idle gap before next request
      check_eq("resp_one_cycle", {31'h0, resp_valid}, 32'd0);
      check_eq("busy_after_done", {31'h0, busy}, 32'd0);
    end
    if (active && we) ref_mem[32'(waddr)] = merge_bytes(ref_rd(waddr), wdata, be);
  endtask

  task automatic reset_mid_write();
    int pulses;
    tick();                                  // cycle 0
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h8000_8000;
    req_wdata = 32'h5A5A_A5A5; req_be = 4'b1111;
    tick();                                  // cycle 1
    tick();                                  // cycle 2
    check_eq("rst_in_pulse_we", {31'h0, sram_we_n}, 32'd0);
    rst = 1'b1; req_valid = 1'b0;
    tick();                                  // cycle 3
    check_eq("rst_we_n", {31'h0, sram_we_n}, 32'd1);
    check_eq("rst_ce_n", {31'h0, sram_ce_n}, 32'd1);
    check_eq("rst_data_oe", {31'h0, sram_data_oe}, 32'd0);
    check_eq("rst_busy", {31'h0, busy}, 32'd0);
    check_eq("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
    req_valid = 1'b1; req_we = 1'b0; req_addr = ADDR_BASE;   // request under reset
    tick();                                  // cycle 4
    check_eq("rst_wins_busy", {31'h0, busy}, 32'd0);
    check_eq("rst_wins_ce_n", {31'h0, sram_ce_n}, 32'd1);
    rst = 1'b0; req_valid = 1'b0;
    pulses = 0;
    repeat (8) begin
      tick();
      if (resp_valid) pulses++;
    end
    check_eq("aborted_no_resp", 32'(pulses), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  be;
    logic        we;
    int unsigned sel;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0;
    req_wdata = 32'h0; req_be = 4'h0; sram_data_in = 32'h0;
    sram_mem[32'h1234] = 32'hDEAD_BEEF;
    ref_mem[32'h1234]  = 32'hDEAD_BEEF;

    repeat (3) tick();
    check_eq("rst_resp_valid0", {31'h0, resp_valid}, 32'd0);
    check_eq("rst_rdata0", resp_rdata, 32'h0);
    check_eq("rst_error0", {31'h0, resp_error}, 32'd0);
    check_eq("rst_busy0", {31'h0, busy}, 32'd0);
    check_eq("rst_addr0", {12'h0, sram_addr}, 32'h0);
    check_eq("rst_dout0", sram_data_out, 32'h0);
    check_eq("rst_oe0", {31'h0, sram_data_oe}, 32'd0);
    check_eq("rst_strobes", {28'h0, sram_ce_n, sram_oe_n, sram_we_n, 1'b0}, 32'hE);
    check_eq("rst_be_n", {28'h0, sram_be_n}, 32'hF);
    rst = 1'b0;
    tick();

    do_req(1'b0, 32'h8000_48D0, 32'h0, 4'h0);              // preloaded word
    do_req(1'b1, 32'h8000_0010, 32'hAABB_CCDD, 4'b0100);   // single-lane write
    do_req(1'b0, 32'h8000_0010, 32'h0, 4'h0);              // back-to-back read
    check_eq("byte_write_model", ref_rd(20'h00004), 32'h00BB_0000);
    do_req(1'b0, 32'h8040_0000, 32'h0, 4'h0);              // just above window
    do_req(1'b0, 32'h7FFF_FFFC, 32'h0, 4'h0);              // just below base
    do_req(1'b1, 32'h8000_48D0, 32'h1111_1111, 4'b0000);   // no lanes
    do_req(1'b0, 32'h8000_48D0, 32'h0, 4'h0);
    do_req(1'b1, 32'h803F_FFFC, 32'hCAFE_F00D, 4'b1111);   // last word of window
    do_req(1'b0, 32'h803F_FFFF, 32'h0, 4'h0);
    do_req(1'b1, 32'h8000_0000, 32'h0102_0304, 4'b1001);   // first word
    do_req(1'b0, 32'h8000_0002, 32'h0, 4'h0);

    reset_mid_write();
    do_req(1'b0, 32'h8000_48D0, 32'h0, 4'h0);

    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 19);
      if (sel < 14)      a = ADDR_BASE + ($urandom_range(0, 63) << 2) + $urandom_range(0, 3);
      else if (sel < 16) a = ADDR_BASE + 32'h003F_FF00 + ($urandom_range(0, 63) << 2);
      else if (sel < 18) a = ADDR_BASE + WIN_BYTES + $urandom_range(0, 255);
      else               a = $urandom();
      we = 1'($urandom_range(0, 1));
      be = 4'($urandom_range(0, 15));
      do_req(we, a, $urandom(), be);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
